hamming_secded_decoder: RTL

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

---
 rtl/hamming_pkg.sv | 64 ++++++
 rtl/hamming_secded_decoder_if.sv | 28 ++
 rtl/hamming_syndrome_calc.sv | 28 ++
 rtl/hamming_secded_decoder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the SECDED decoder.
// Everything here is constant-foldable so that codeword layout tables come
// from loops, not from hand-written bit lists.
package hamming_pkg;

    // Decoder status reported with every output word
    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_SINGLE_CORR = 2'd1,
        ERR_PARITY_ONLY = 2'd2,
        ERR_DOUBLE_DET  = 2'd3
    } err_t;

    // Largest parity width searched; 6 covers DATA_W up to 57, well past 32
    localparam int MAX_P_W = 6;

    // True when n is a power of two (Hamming parity positions)
    function automatic bit is_pow2(input int n);
        return (n > 32'sd0) && ((n & (n - 32'sd1)) == 32'sd0);
    endfunction

    // Smallest p with 2^p >= data_w + p + 1
    function automatic int calc_parity_bits(input int data_w);
        int p;
        p = 32'sd0;
        for (int k = MAX_P_W; k >= 1; k--) begin
            if ((32'sd1 <<< k) >= (data_w + k + 32'sd1)) begin
                p = k;
            end
        end
        return p;
    endfunction

    // Syndrome width from the full codeword width: smallest p with 2^p >= code_w
    function automatic int calc_syn_width(input int code_w);
        int p;
        p = 32'sd0;
        for (int k = MAX_P_W; k >= 1; k--) begin
            if ((32'sd1 <<< k) >= code_w) begin
                p = k;
            end
        end
        return p;
    endfunction

    // Codeword bit index holding data bit j: data fills the non-power-of-two
    // Hamming positions in ascending order, bit index = position - 1
    function automatic int data_bit_index(input int j);
        int seen;
        int idx;
        seen = 32'sd0;
        idx  = 32'sd0;
        for (int pos = 1; pos <= 64; pos++) begin
            if (!is_pow2(pos)) begin
                if (seen == j) begin
                    idx = pos - 32'sd1;
                end
                seen = seen + 32'sd1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hamming_secded_decoder_if.sv
// Stream handshake bundle between a codeword producer, the decoder and the
// result consumer. The decoder sits on the slave side.
interface hamming_secded_decoder_if #(
    parameter int DATA_W = 4
);
    localparam int P_W    = hamming_pkg::calc_parity_bits(DATA_W);
    localparam int CODE_W = DATA_W + P_W + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [CODE_W-1:0]       in_code;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [P_W-1:0]          out_syndrome;
    hamming_pkg::err_t       out_err;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_syndrome, out_err
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_syndrome, out_err
    );

endinterface

// File: rtl/hamming_syndrome_calc.sv
// Combinational Hamming syndrome and overall-parity check for one codeword.
// Bit i of the word is Hamming position i+1; the top bit is the overall parity.
module hamming_syndrome_calc
    import hamming_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int P_W    = calc_syn_width(CODE_W)
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [P_W-1:0]    syndrome_o,
    output logic              check_o
);

    // Fold every set position into the syndrome bits its index covers
    always_comb begin
        logic [31:0] pos_v;
        pos_v      = 32'd0;
        syndrome_o = {P_W{1'b0}};
        for (int i = 0; i < CODE_W - 1; i++) begin
            pos_v = 32'(i + 1);
            for (int k = 0; k < P_W; k++) begin
                syndrome_o[k] = syndrome_o[k] ^ (code_i[i] & pos_v[k]);
            end
        end
        check_o = ^code_i;
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage SECDED decoder with valid/ready on both sides.
// Stage 1 captures the codeword with its syndrome and overall check;
// stage 2 classifies, corrects a single-bit error, and extracts data.
// Saturating counters track corrected and uncorrectable words.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int P_W    = calc_parity_bits(DATA_W),
    localparam int CODE_W = DATA_W + P_W + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    hamming_secded_decoder_if.slave    bus,
    input  logic                       clr_cnt,
    output logic [CNT_W-1:0]           cnt_corr,
    output logic [CNT_W-1:0]           cnt_uncorr
);

    // Pipeline state
    logic                s1_valid_q,  s1_valid_d;
    logic [CODE_W-1:0]   s1_code_q,   s1_code_d;
    logic [P_W-1:0]      s1_syn_q,    s1_syn_d;
    logic                s1_chk_q,    s1_chk_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [P_W-1:0]      out_syn_q,   out_syn_d;
    err_t                out_err_q,   out_err_d;
    logic [CNT_W-1:0]    cnt_corr_q,  cnt_corr_d;
    logic [CNT_W-1:0]    cnt_uncorr_q, cnt_uncorr_d;

    // Combinational helpers
    logic [P_W-1:0]      calc_syn_s;
    logic                calc_chk_s;
    logic                adv2_s;
    logic                adv1_s;
    logic                in_fire_s;
    logic                out_fire_s;
    err_t                dec_err_s;
    logic [CODE_W-1:0]   corr_code_s;
    logic [DATA_W-1:0]   dec_data_s;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    hamming_syndrome_calc #(
        .CODE_W (CODE_W),
        .P_W    (P_W)
    ) u_syn (
        .code_i     (bus.in_code),
        .syndrome_o (calc_syn_s),
        .check_o    (calc_chk_s)
    );

    // Stage advance: a stage moves when it is empty or its successor moves
    always_comb begin
        adv2_s     = ~out_valid_q | bus.out_ready;
        adv1_s     = ~s1_valid_q | adv2_s;
        in_fire_s  = bus.in_valid & adv1_s & ~rst;
        out_fire_s = out_valid_q & bus.out_ready;
    end

    // Classify the stage-1 word from its syndrome and overall check
    always_comb begin
        dec_err_s = ERR_NONE;
        if (s1_syn_q == {P_W{1'b0}}) begin
            if (s1_chk_q) begin
                dec_err_s = ERR_PARITY_ONLY;
            end else begin
                dec_err_s = ERR_NONE;
            end
        end else if (s1_chk_q && (int'(s1_syn_q) <= (CODE_W - 32'sd1))) begin
            dec_err_s = ERR_SINGLE_CORR;
        end else begin
            dec_err_s = ERR_DOUBLE_DET;
        end
    end

    // Flip the bit the syndrome points at, only for a correctable word
    always_comb begin
        corr_code_s = s1_code_q;
        for (int i = 0; i < CODE_W; i++) begin
            corr_code_s[i] = s1_code_q[i]
                           ^ ((dec_err_s == ERR_SINGLE_CORR) && (int'(s1_syn_q) == (i + 32'sd1)));
        end
    end

    // Data extraction from the non-power-of-two positions
    for (genvar j = 0; j < DATA_W; j++) begin : g_data_map
        localparam int BIT_IDX = data_bit_index(j);
        assign dec_data_s[j] = corr_code_s[BIT_IDX];
    end

    // Next-state for both pipeline stages
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_syn_d    = s1_syn_q;
        s1_chk_d    = s1_chk_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        out_err_d   = out_err_q;

        if (adv1_s) begin
            s1_valid_d = in_fire_s;
            if (in_fire_s) begin
                s1_code_d = bus.in_code;
                s1_syn_d  = calc_syn_s;
                s1_chk_d  = calc_chk_s;
            end else begin
                s1_code_d = s1_code_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (adv2_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = dec_data_s;
                out_syn_d  = s1_syn_q;
                out_err_d  = dec_err_s;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Saturating error counters; a clear beats a same-cycle increment
    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (clr_cnt) begin
            cnt_corr_d   = {CNT_W{1'b0}};
            cnt_uncorr_d = {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            case (out_err_q)
                ERR_SINGLE_CORR, ERR_PARITY_ONLY: begin
                    if (cnt_corr_q != CNT_MAX) begin
                        cnt_corr_d = cnt_corr_q + CNT_ONE;
                    end else begin
                        cnt_corr_d = cnt_corr_q;
                    end
                end
                ERR_DOUBLE_DET: begin
                    if (cnt_uncorr_q != CNT_MAX) begin
                        cnt_uncorr_d = cnt_uncorr_q + CNT_ONE;
                    end else begin
                        cnt_uncorr_d = cnt_uncorr_q;
                    end
                end
                default: begin
                    cnt_corr_d   = cnt_corr_q;
                    cnt_uncorr_d = cnt_uncorr_q;
                end
            endcase
        end else begin
            cnt_corr_d = cnt_corr_q;
        end
    end

    // State registers with synchronous reset that empties the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= {CODE_W{1'b0}};
            s1_syn_q     <= {P_W{1'b0}};
            s1_chk_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= {DATA_W{1'b0}};
            out_syn_q    <= {P_W{1'b0}};
            out_err_q    <= ERR_NONE;
            cnt_corr_q   <= {CNT_W{1'b0}};
            cnt_uncorr_q <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_chk_q     <= s1_chk_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_syn_q    <= out_syn_d;
            out_err_q    <= out_err_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign bus.in_ready     = adv1_s & ~rst;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_syndrome = out_syn_q;
    assign bus.out_err      = out_err_q;
    assign cnt_corr         = cnt_corr_q;
    assign cnt_uncorr       = cnt_uncorr_q;

endmodule
